// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle divider: FSM encodings, handshake
// levels, bus widths and the EX opcodes that route work to the divider.
package div_unit_pkg;

  localparam int DIV_DW = 32;

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [DIV_DW-1:0]   ZERO_WORD   = 32'h0000_0000;
  localparam logic [2*DIV_DW-1:0] ZERO_DOUBLE = 64'h0000_0000_0000_0000;

  typedef logic [2*DIV_DW-1:0] double_reg_bus_t;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // A request is only taken when EX asks and is not flushing the slot.
  function automatic logic div_accept(input logic start, input logic annul);
    return (start == DIV_START) && !annul;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock, signs
// handled by dividing magnitudes and fixing up the result at the end.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DW   = DIV_DW,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam logic [DW-1:0]   ZERO_W   = {DW{1'b0}};
  localparam logic [DW-1:0]   ONE_W    = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [2*DW-1:0] ZERO_D   = {(2*DW){1'b0}};
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DW);

  function automatic logic [DW-1:0] twos_neg(input logic [DW-1:0] v);
    return ~v + ONE_W;
  endfunction

  logic [1:0]      state_r;
  logic [CNTW-1:0] cnt_r;
  logic [DW-1:0]   rem_r;
  logic [DW-1:0]   quo_r;
  logic [DW-1:0]   divisor_r;
  logic            sign1_r;
  logic            sign2_r;
  logic            signed_r;

  logic            accept_s;
  logic [DW-1:0]   abs1_s;
  logic [DW-1:0]   abs2_s;
  logic [DW:0]     minuend_s;
  logic [DW:0]     diff_s;
  logic [DW-1:0]   step_rem_s;
  logic [DW-1:0]   step_quo_s;
  logic [DW-1:0]   fix_rem_s;
  logic [DW-1:0]   fix_quo_s;

  // Operand magnitudes, one restoring step and the final sign fix-up.
  always_comb begin
    accept_s   = div_accept(start_i, annul_i);
    abs1_s     = opdata1_i;
    abs2_s     = opdata2_i;
    minuend_s  = {rem_r, quo_r[DW-1]};
    diff_s     = minuend_s - {1'b0, divisor_r};
    step_rem_s = rem_r;
    step_quo_s = quo_r;
    fix_rem_s  = rem_r;
    fix_quo_s  = quo_r;

    if (signed_div_i && opdata1_i[DW-1]) begin
      abs1_s = twos_neg(opdata1_i);
    end else begin
      abs1_s = opdata1_i;
    end

    if (signed_div_i && opdata2_i[DW-1]) begin
      abs2_s = twos_neg(opdata2_i);
    end else begin
      abs2_s = opdata2_i;
    end

    // A clear borrow bit means the divisor fits: keep the difference.
    if (!diff_s[DW]) begin
      step_rem_s = diff_s[DW-1:0];
      step_quo_s = {quo_r[DW-2:0], 1'b1};
    end else begin
      step_rem_s = minuend_s[DW-1:0];
      step_quo_s = {quo_r[DW-2:0], 1'b0};
    end

    if (signed_r && (sign1_r ^ sign2_r)) begin
      fix_quo_s = twos_neg(quo_r);
    end else begin
      fix_quo_s = quo_r;
    end

    // The remainder takes the sign of the dividend.
    if (signed_r && sign1_r) begin
      fix_rem_s = twos_neg(rem_r);
    end else begin
      fix_rem_s = rem_r;
    end
  end

  // Divider FSM, iteration counter, working register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= DIV_FREE;
      cnt_r     <= CNT_ZERO;
      rem_r     <= ZERO_W;
      quo_r     <= ZERO_W;
      divisor_r <= ZERO_W;
      sign1_r   <= 1'b0;
      sign2_r   <= 1'b0;
      signed_r  <= 1'b0;
      result_o  <= ZERO_D;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_r)
        DIV_FREE: begin
          result_o <= ZERO_D;
          ready_o  <= DIV_RESULT_NOT_READY;
          cnt_r    <= CNT_ZERO;
          if (accept_s) begin
            if (opdata2_i == ZERO_W) begin
              state_r <= DIV_BY_ZERO;
            end else begin
              state_r   <= DIV_ON;
              rem_r     <= ZERO_W;
              quo_r     <= abs1_s;
              divisor_r <= abs2_s;
              sign1_r   <= opdata1_i[DW-1];
              sign2_r   <= opdata2_i[DW-1];
              signed_r  <= signed_div_i;
            end
          end else begin
            state_r <= DIV_FREE;
          end
        end

        DIV_BY_ZERO: begin
          state_r <= DIV_END;
          rem_r   <= ZERO_W;
          quo_r   <= ZERO_W;
        end

        DIV_ON: begin
          if (annul_i) begin
            state_r  <= DIV_FREE;
            cnt_r    <= CNT_ZERO;
            result_o <= ZERO_D;
            ready_o  <= DIV_RESULT_NOT_READY;
          end else if (cnt_r != CNT_LAST) begin
            rem_r <= step_rem_s;
            quo_r <= step_quo_s;
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            state_r  <= DIV_END;
            cnt_r    <= CNT_ZERO;
            rem_r    <= fix_rem_s;
            quo_r    <= fix_quo_s;
            result_o <= {fix_rem_s, fix_quo_s};
            ready_o  <= DIV_RESULT_READY;
          end
        end

        // Hold the answer until EX drops its request; flushes are too late here.
        DIV_END: begin
          if (start_i == DIV_START) begin
            result_o <= {rem_r, quo_r};
            ready_o  <= DIV_RESULT_READY;
          end else begin
            state_r  <= DIV_FREE;
            result_o <= ZERO_D;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end

        default: begin
          state_r  <= DIV_FREE;
          cnt_r    <= CNT_ZERO;
          result_o <= ZERO_D;
          ready_o  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule
